source_id_queue: RTL and testbench
==================================

Name: source_id_queue

Overview:
- Parametrised ready/valid FIFO for TileLink source IDs and similar small tags.
- Storage is a 1-read/1-write register array with an asynchronous read port, generalised to any width and depth.
- Adds full queue control: pointers, occupancy count, and optional flow/pipe bypass modes.
- Sits between a source-ID allocator and its consumer in the memory-system front end.

Parameters:
- WIDTH, 7, bits per entry (>=1)
- DEPTH, 2, number of entries (>=1; need not be a power of two)
- FLOW, 0, 1 = an empty queue passes enq to deq combinationally
- PIPE, 0, 1 = enq_ready is also asserted when full and deq_ready=1

Ports:
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- enq_valid  in  1  producer has data
- enq_ready  out  1  queue accepts data this cycle
- enq_bits  in  WIDTH  write data
- deq_valid  out  1  data available
- deq_ready  in  1  consumer takes data
- deq_bits  out  WIDTH  head entry, read asynchronously
- count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
- deq_perr  out  1  parity error on the head entry (see Optional Feature)

Behaviour:
- State: wr_ptr, rd_ptr (each $clog2(DEPTH) bits, minimum 1), maybe_full flag, and mem[DEPTH].
- Flags:
  - empty = (wr_ptr==rd_ptr) && !maybe_full
  - full = (wr_ptr==rd_ptr) && maybe_full
- Reset: wr_ptr=0, rd_ptr=0, maybe_full=0. Memory contents are not reset.
- Outputs during and right after reset: deq_valid=0, count=0, enq_ready=1, deq_perr=0.
- Base handshake:
  - enq_ready = !full
  - deq_valid = !empty
  - deq_bits = mem[rd_ptr], combinational; latency from enqueue to deq_valid is 1 cycle.
- do_enq = enq_valid && enq_ready; do_deq = deq_valid && deq_ready.
- On do_enq: mem[wr_ptr] <= enq_bits; wr_ptr advances.
- On do_deq: rd_ptr advances.
- Pointer wrap: a pointer at DEPTH-1 advances to 0. It never takes values >= DEPTH, including when DEPTH is not a power of two.
- maybe_full update: when do_enq != do_deq, maybe_full <= do_enq. When both or neither fire, it holds.
- count:
  - ptr_diff = wr_ptr - rd_ptr, modulo DEPTH
  - full -> DEPTH; empty -> 0; otherwise ptr_diff (add DEPTH when wr_ptr < rd_ptr)
- Simultaneous enq and deq on a non-empty, non-full queue: both pointers move and count is unchanged.
- FLOW=1 while empty:
  - deq_valid = enq_valid and deq_bits = enq_bits.
  - If deq_ready=1, the entry bypasses: no write, pointers hold.
  - If deq_ready=0, the entry is written normally.
- PIPE=1: enq_ready = !full || deq_ready. When full and deq_ready=1, an enqueue and a dequeue occur in the same cycle (write lands in the slot being vacated; wr_ptr==rd_ptr).
- Reset asserted mid-traffic: pointers and flag clear on the next edge; any entries in flight are discarded; do_enq in that cycle is ignored.
- DEPTH=1: the pointers stay at 0 and maybe_full alone distinguishes full from empty.

Optional Feature:
- Macro: SOURCE_ID_QUEUE_PARITY_EN
- Defined:
  - Each entry stores WIDTH+1 bits; the extra bit is the even parity (XOR) of enq_bits, computed at write.
  - deq_perr = deq_valid && (^deq_bits != stored parity bit), combinational with deq_bits.
  - In FLOW bypass, parity is computed from enq_bits, so deq_perr=0.
- Not defined: the memory is WIDTH bits and deq_perr is tied to 0.
- Port list is identical in both builds.

Test Plan:
- Reset, then DEPTH=2 WIDTH=7: enq 7'h15, then 7'h2A, deq_ready=0 -> enq_ready=0 after the 2nd enq, count=2; then deq_ready=1 -> deq_bits 7'h15 then 7'h2A; count falls 2->1->0; deq_valid=0 at the end.
- DEPTH=3, 10 back-to-back enq/deq pairs of values 0..9 with deq_ready=1 -> in-order output 0..9; pointers wrap 2->0; count never exceeds 1.
- FLOW=1, empty queue, enq_valid=1 with 7'h33, deq_ready=1 -> deq_valid=1 and deq_bits=7'h33 in the same cycle; count stays 0.
- PIPE=1, DEPTH=2 full (7'h01, 7'h02), enq 7'h03 with deq_ready=1 -> enq_ready=1, 7'h01 dequeued, count stays 2; next outputs 7'h02 then 7'h03.
- Fill to count=2, assert reset one cycle while enq_valid=1 -> count=0, deq_valid=0, enq_ready=1 on the following cycle.
- PARITY_EN build: enq 7'h07, force-flip mem bit0 via the hierarchical path -> deq_perr=1. Clean 7'h07 -> deq_perr=0. Non-parity build: deq_perr always 0.

Source files
------------

// File: rtl/source_id_queue.sv
// source_id_queue: ready/valid FIFO for small tags with optional flow/pipe bypass.
// Define SOURCE_ID_QUEUE_PARITY_EN to store a parity bit per entry and report it on deq_perr.
module source_id_queue #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 2,
  parameter bit FLOW  = 1'b0,
  parameter bit PIPE  = 1'b0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [WIDTH-1:0]           enq_bits,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [WIDTH-1:0]           deq_bits,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       deq_perr
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
`ifdef SOURCE_ID_QUEUE_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif
  logic [MW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          maybe_full_q, maybe_full_d;
  logic          ptr_match, empty, full, flow_empty, do_enq, do_deq, wr_en, rd_en;
  logic [MW-1:0] head, wdata;
  logic [CW-1:0] wr_ext, rd_ext;

  // Wrap at DEPTH-1 so non-power-of-two depths never reach an unused slot.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign ptr_match  = wr_ptr_q == rd_ptr_q;
  assign empty      = ptr_match && !maybe_full_q;
  assign full       = ptr_match && maybe_full_q;
  assign flow_empty = FLOW && empty;
  assign head       = mem_q[rd_ptr_q];

  assign enq_ready = reset || !full || (PIPE && deq_ready);
  assign deq_valid = !reset && (flow_empty ? enq_valid : !empty);
  assign deq_bits  = flow_empty ? enq_bits : head[WIDTH-1:0];
  assign do_enq    = enq_valid && enq_ready;
  assign do_deq    = deq_valid && deq_ready;
  // A flow-through transfer on an empty queue touches neither storage nor pointers.
  assign wr_en     = !reset && do_enq && !(flow_empty && deq_ready);
  assign rd_en     = do_deq && !flow_empty;

  assign wr_ext = CW'(wr_ptr_q);
  assign rd_ext = CW'(rd_ptr_q);
  assign count  = (reset || empty) ? '0 : full ? CW'(DEPTH) :
                  (wr_ext >= rd_ext) ? wr_ext - rd_ext : wr_ext + CW'(DEPTH) - rd_ext;

`ifdef SOURCE_ID_QUEUE_PARITY_EN
  assign wdata    = {^enq_bits, enq_bits};
  assign deq_perr = deq_valid && !flow_empty && ((^head[WIDTH-1:0]) != head[WIDTH]);
`else
  assign wdata    = enq_bits;
  assign deq_perr = 1'b0;
`endif

  always_comb begin
    wr_ptr_d     = wr_en ? bump(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d     = rd_en ? bump(rd_ptr_q) : rd_ptr_q;
    maybe_full_d = (wr_en != rd_en) ? wr_en : maybe_full_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      maybe_full_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      maybe_full_q <= maybe_full_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: tb/tb_source_id_queue.sv
// tb_source_id_queue: directed checks of base, depth-3, flow, pipe and depth-1 queues.
module tb_source_id_queue;
  logic       clk = 1'b0;
  logic       rst;
  logic       ev [5], dr [5], er [5], dv [5], pe [5];
  logic [6:0] eb [5], db [5];
  logic [1:0] cnt [4];
  logic [0:0] cnt1;
  int         checks = 0, failures = 0;

  always #5 clk = ~clk;

  source_id_queue #(.WIDTH(7), .DEPTH(2)) u_q0 (.clock(clk), .reset(rst), .enq_valid(ev[0]), .enq_ready(er[0]),
    .enq_bits(eb[0]), .deq_valid(dv[0]), .deq_ready(dr[0]), .deq_bits(db[0]), .count(cnt[0]), .deq_perr(pe[0]));
  source_id_queue #(.WIDTH(7), .DEPTH(3)) u_q1 (.clock(clk), .reset(rst), .enq_valid(ev[1]), .enq_ready(er[1]),
    .enq_bits(eb[1]), .deq_valid(dv[1]), .deq_ready(dr[1]), .deq_bits(db[1]), .count(cnt[1]), .deq_perr(pe[1]));
  source_id_queue #(.WIDTH(7), .DEPTH(2), .FLOW(1'b1)) u_q2 (.clock(clk), .reset(rst), .enq_valid(ev[2]), .enq_ready(er[2]),
    .enq_bits(eb[2]), .deq_valid(dv[2]), .deq_ready(dr[2]), .deq_bits(db[2]), .count(cnt[2]), .deq_perr(pe[2]));
  source_id_queue #(.WIDTH(7), .DEPTH(2), .PIPE(1'b1)) u_q3 (.clock(clk), .reset(rst), .enq_valid(ev[3]), .enq_ready(er[3]),
    .enq_bits(eb[3]), .deq_valid(dv[3]), .deq_ready(dr[3]), .deq_bits(db[3]), .count(cnt[3]), .deq_perr(pe[3]));
  source_id_queue #(.WIDTH(7), .DEPTH(1)) u_q4 (.clock(clk), .reset(rst), .enq_valid(ev[4]), .enq_ready(er[4]),
    .enq_bits(eb[4]), .deq_valid(dv[4]), .deq_ready(dr[4]), .deq_bits(db[4]), .count(cnt1), .deq_perr(pe[4]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      ev[k] = 1'b0; dr[k] = 1'b0; eb[k] = '0;
    end
    tick; tick;
    check("rst_dv", dv[0], 0); check("rst_cnt", cnt[0], 0); check("rst_er", er[0], 1); check("rst_pe", pe[0], 0);
    rst = 1'b0;
    #1;
    check("post_rst_dv", dv[0], 0); check("post_rst_cnt", cnt[0], 0); check("post_rst_er", er[0], 1);

    ev[0] = 1'b1; eb[0] = 7'h15;
    tick;
    eb[0] = 7'h2A; #1;
    check("b_dv1", dv[0], 1); check("b_bits1", db[0], 7'h15); check("b_cnt1", cnt[0], 1); check("b_er1", er[0], 1);
    tick;
    ev[0] = 1'b0; #1;
    check("b_er_full", er[0], 0); check("b_cnt2", cnt[0], 2); check("b_pe", pe[0], 0);
    dr[0] = 1'b1; #1;
    check("b_head0", db[0], 7'h15);
    tick;
    check("b_head1", db[0], 7'h2A); check("b_cnt_dn1", cnt[0], 1); check("b_er_again", er[0], 1);
    tick;
    check("b_cnt_dn0", cnt[0], 0); check("b_dv_end", dv[0], 0);
    dr[0] = 1'b0;

    for (int i = 0; i < 10; i++) begin
      ev[1] = 1'b1; eb[1] = 7'(i); dr[1] = 1'b1; #1;
      check("d3_dv", dv[1], i > 0); check("d3_cnt", cnt[1], i > 0);
      if (i > 0) check("d3_bits", db[1], i - 1);
      tick;
    end
    ev[1] = 1'b0; #1;
    check("d3_last", db[1], 9); check("d3_wr_ptr", u_q1.wr_ptr_q, 1); check("d3_rd_ptr", u_q1.rd_ptr_q, 0);
    tick;
    check("d3_empty", dv[1], 0); check("d3_rd_wrap", u_q1.rd_ptr_q, 1);
    dr[1] = 1'b0;

    ev[2] = 1'b1; eb[2] = 7'h33; dr[2] = 1'b1; #1;
    check("fl_dv", dv[2], 1); check("fl_bits", db[2], 7'h33); check("fl_cnt", cnt[2], 0); check("fl_pe", pe[2], 0);
    tick;
    ev[2] = 1'b0; #1;
    check("fl_cnt_after", cnt[2], 0); check("fl_dv_after", dv[2], 0);
    ev[2] = 1'b1; eb[2] = 7'h44; dr[2] = 1'b0;
    tick;
    ev[2] = 1'b0; #1;
    check("fl_stored_cnt", cnt[2], 1); check("fl_stored_bits", db[2], 7'h44);
    dr[2] = 1'b1;
    tick;
    check("fl_drained", cnt[2], 0);
    dr[2] = 1'b0;

    ev[3] = 1'b1; eb[3] = 7'h01;
    tick;
    eb[3] = 7'h02;
    tick;
    ev[3] = 1'b0; #1;
    check("pp_full_er", er[3], 0); check("pp_full_cnt", cnt[3], 2);
    ev[3] = 1'b1; eb[3] = 7'h03; dr[3] = 1'b1; #1;
    check("pp_er", er[3], 1); check("pp_head", db[3], 7'h01);
    tick;
    ev[3] = 1'b0; #1;
    check("pp_cnt_hold", cnt[3], 2); check("pp_next", db[3], 7'h02);
    tick;
    check("pp_last", db[3], 7'h03); check("pp_cnt1", cnt[3], 1);
    tick;
    check("pp_empty", dv[3], 0);
    dr[3] = 1'b0;

    ev[4] = 1'b1; eb[4] = 7'h5A;
    tick;
    ev[4] = 1'b0; #1;
    check("d1_cnt", cnt1, 1); check("d1_er", er[4], 0); check("d1_bits", db[4], 7'h5A); check("d1_ptr", u_q4.wr_ptr_q, 0);
    dr[4] = 1'b1;
    tick;
    check("d1_cnt0", cnt1, 0); check("d1_er1", er[4], 1);
    dr[4] = 1'b0;

    ev[0] = 1'b1; eb[0] = 7'h11;
    tick;
    eb[0] = 7'h22;
    tick;
    eb[0] = 7'h55; #1;
    check("rm_cnt_full", cnt[0], 2);
    rst = 1'b1;
    tick;
    rst = 1'b0; ev[0] = 1'b0; #1;
    check("rm_cnt", cnt[0], 0); check("rm_dv", dv[0], 0); check("rm_er", er[0], 1);
    tick;
    check("rm_cnt_stay", cnt[0], 0);

`ifdef SOURCE_ID_QUEUE_PARITY_EN
    ev[0] = 1'b1; eb[0] = 7'h07;
    tick;
    ev[0] = 1'b0; #1;
    check("par_clean", pe[0], 0);
    u_q0.mem_q[u_q0.rd_ptr_q][0] = ~u_q0.mem_q[u_q0.rd_ptr_q][0];
    #1;
    check("par_flip", pe[0], 1);
    dr[0] = 1'b1;
    tick;
    dr[0] = 1'b0; #1;
    check("par_empty", pe[0], 0);
`else
    ev[0] = 1'b1; eb[0] = 7'h07;
    tick;
    ev[0] = 1'b0; #1;
    check("nopar_pe", pe[0], 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
